alu_div_unit: RTL

- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU), the counterpart to the single-cycle add/or/shift ALU.
- Sits beside the ALU in the execute stage. Operands arrive from the register-file read ports.
- Uses a Start/Busy/Done handshake so the control unit stalls the PC while Busy_o is high.
- Restoring algorithm, one quotient bit per clock.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/div_step.sv | 36 +++
 rtl/alu_div_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage divide unit.
//   DATA_WIDTH : default operand/result width
//   div_op_e   : Div_Op_i encoding (DIV, DIVU, REM, REMU)
//   div_state_e: divider FSM state encoding
//   ALL_ONES / INT_MIN : special-case result constants at the default width
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem_in       : partial remainder from the previous step
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_out      : partial remainder after the trial subtract
//   q_bit        : quotient bit produced by this step
module div_step
  import alu_pkg::*;
#(
  parameter int unsigned W = DATA_WIDTH
) (
  input  logic [W-1:0] rem_in,
  input  logic         dividend_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  // The shifted remainder keeps rem_in's MSB: with unsigned divisors above
  // 2^(W-1) the partial remainder can legitimately use all W bits.
  logic [W:0]   partial;
  logic [W+1:0] diff;
  logic         unused_bits;

  assign partial = {rem_in, dividend_msb};
  assign diff    = {1'b0, partial} - {2'b00, divisor};

  // Top bit of the widened difference is the borrow.
  assign q_bit   = ~diff[W+1];
  assign rem_out = q_bit ? diff[W-1:0] : partial[W-1:0];

  // Discarded bits: diff[W] is zero whenever it is selected, partial[W]
  // only matters through the subtract.
  assign unused_bits = ^{diff[W], partial[W]};

endmodule

// File: rtl/alu_div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring division, one quotient bit per clock; divide-by-zero and signed
// overflow complete in a single cycle.
//   clk, reset : clock and synchronous active-low reset
//   Start_i    : request, accepted when not busy
//   Div_Op_i   : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A_i, B_i   : dividend, divisor
//   Busy_o     : iterating
//   Done_o     : one-cycle completion pulse
//   Result_o   : quotient or remainder, held until the next result load
//   Zero_o     : Result_o == 0
module alu_div_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [1:0]            Div_Op_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [DATA_WIDTH-1:0] Result_o,
  output logic                  Zero_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(W - 1);
  localparam logic [W-1:0]     RES_ONES  = '1;
  localparam logic [W-1:0]     RES_MIN   = {1'b1, {(W-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     dividend_q, dividend_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;

  logic [W-1:0] step_rem;
  logic         step_q;
  logic [W-1:0] quot_final;

  // Decoded request fields
  logic         op_signed;
  logic         op_rem;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic         div_by_zero;
  logic         overflow;

  div_step #(.W(W)) u_step (
    .rem_in       (rem_q),
    .dividend_msb (dividend_q[W-1]),
    .divisor      (divisor_q),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  assign op_signed   = ~Div_Op_i[0];
  assign op_rem      = Div_Op_i[1];
  assign a_neg       = op_signed & A_i[W-1];
  assign b_neg       = op_signed & B_i[W-1];
  assign a_mag       = a_neg ? (W'(0) - A_i) : A_i;
  assign b_mag       = b_neg ? (W'(0) - B_i) : B_i;
  assign div_by_zero = (B_i == '0);
  assign overflow    = op_signed & (A_i == RES_MIN) & (B_i == RES_ONES);
  assign quot_final  = {quot_q[W-2:0], step_q};

  // State and datapath register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      result_q   <= '0;
      is_rem_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      result_q   <= result_d;
      is_rem_q   <= is_rem_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    result_d   = result_q;
    is_rem_d   = is_rem_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;

    case (state_q)
      RUN: begin
        dividend_d = {dividend_q[W-2:0], 1'b0};
        rem_d      = step_rem;
        quot_d     = quot_final;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (is_rem_q) result_d = neg_r_q ? (W'(0) - step_rem) : step_rem;
          else          result_d = neg_q_q ? (W'(0) - quot_final) : quot_final;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // IDLE and DONE both accept a new request
        if (Start_i) begin
          is_rem_d = op_rem;
          if (div_by_zero) begin
            state_d  = DONE;
            result_d = op_rem ? A_i : RES_ONES;
          end else if (overflow) begin
            state_d  = DONE;
            result_d = op_rem ? '0 : RES_MIN;
          end else begin
            state_d    = RUN;
            cnt_d      = '0;
            dividend_d = a_mag;
            divisor_d  = b_mag;
            rem_d      = '0;
            quot_d     = '0;
            neg_q_d    = a_neg ^ b_neg;
            neg_r_d    = a_neg;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign Busy_o   = (state_q == RUN);
  assign Done_o   = (state_q == DONE);
  assign Result_o = result_q;
  assign Zero_o   = (result_q == '0);

endmodule
